// File: rtl/secure_tdm_arbiter_pkg.sv
// Shared types and defaults for the two-domain time-division arbiter.
// Holds the slot state encoding and the slot-length helper used by the FSM.
package secure_tdm_arbiter_pkg;

   localparam int DW_DEFAULT       = 4;
   localparam int SLOT_LEN_DEFAULT = 4;
   localparam int CNT_W            = 8;

   typedef enum logic [1:0] {
      L_SLOT = 2'd0,
      H_SLOT = 2'd1,
      SCRUB  = 2'd2
   } slot_state_e;

   // SCRUB is always a single cycle; the data slots use the configured length.
   function automatic logic [CNT_W-1:0] slot_len_of(input slot_state_e st,
                                                    input logic [CNT_W-1:0] len);
      return (st == SCRUB) ? CNT_W'(1) : len;
   endfunction

endpackage

// File: rtl/secure_tdm_arbiter_slot_timer.sv
// Slot cycle counter: counts up from 0 and pulses wrap in the last cycle of a slot.
// The count restarts at 0 on the edge that closes the wrap cycle.
module slot_timer
   import secure_tdm_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] len,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      wrap  = (cnt_q == (len - CNT_W'(1)));
      cnt_d = wrap ? '0 : (cnt_q + CNT_W'(1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/secure_tdm_arbiter.sv
// Fixed-schedule arbiter sharing one accumulator between a low and a high domain.
// Schedule: L_SLOT (SLOT_LEN) -> H_SLOT (SLOT_LEN) -> SCRUB (1) -> L_SLOT.
//
// state  | meaning
// L_SLOT | low-domain requests are served, acc carries low data only
// H_SLOT | high-domain requests are served, acc may hold high data
// SCRUB  | no service; acc is cleared before the low domain regains it
module secure_tdm_arbiter
   import secure_tdm_arbiter_pkg::*;
#(
   parameter int DW       = DW_DEFAULT,
   parameter int SLOT_LEN = SLOT_LEN_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          l_req,
   input  logic [DW-1:0] l_data,
   input  logic          h_req,
   input  logic [DW-1:0] h_data,
   output logic          l_ack,
   output logic [DW-1:0] l_result,
   output logic          h_ack,
   output logic [DW-1:0] h_result,
   output logic          slot_h
);

   localparam logic [CNT_W-1:0] SLOT_LEN_C = CNT_W'(SLOT_LEN);

   slot_state_e      state_q;
   slot_state_e      state_d;
   logic             wrap;
   logic [CNT_W-1:0] timer_len;
   logic             l_accept;
   logic             h_accept;
   logic             scrub;

   logic [DW-1:0]    acc_q,      acc_d;
   logic             l_ack_q,    l_ack_d;
   logic [DW-1:0]    l_result_q, l_result_d;
   logic             h_ack_q,    h_ack_d;
   logic [DW-1:0]    h_result_q, h_result_d;

   slot_timer u_slot_timer (
      .clk   (clk),
      .reset (reset),
      .len   (timer_len),
      .wrap  (wrap)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= L_SLOT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         L_SLOT:  if (wrap) state_d = H_SLOT;
         H_SLOT:  if (wrap) state_d = SCRUB;
         SCRUB:   if (wrap) state_d = L_SLOT;
         default: state_d = L_SLOT;
      endcase
   end

   always_comb begin
      timer_len = slot_len_of(state_q, SLOT_LEN_C);
      slot_h    = (state_q == H_SLOT);
      l_accept  = (state_q == L_SLOT) && l_req;
      h_accept  = (state_q == H_SLOT) && h_req;
      scrub     = (state_q == SCRUB);
   end

   // Results hold between operations; the ack registers pulse for one cycle
   // after each accept, even when that cycle already belongs to the next slot.
   always_comb begin
      acc_d      = acc_q;
      l_ack_d    = l_accept;
      l_result_d = l_result_q;
      h_ack_d    = h_accept;
      h_result_d = h_result_q;
      if (l_accept) begin
         acc_d      = acc_q + l_data;
         l_result_d = acc_q + l_data;
      end else if (h_accept) begin
         acc_d      = acc_q + h_data;
         h_result_d = acc_q + h_data;
      end else if (scrub) begin
         acc_d      = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q      <= '0;
         l_ack_q    <= 1'b0;
         l_result_q <= '0;
         h_ack_q    <= 1'b0;
         h_result_q <= '0;
      end else begin
         acc_q      <= acc_d;
         l_ack_q    <= l_ack_d;
         l_result_q <= l_result_d;
         h_ack_q    <= h_ack_d;
         h_result_q <= h_result_d;
      end
   end

   assign l_ack    = l_ack_q;
   assign l_result = l_result_q;
   assign h_ack    = h_ack_q;
   assign h_result = h_result_q;

endmodule
